// File: rtl/cpu7_ifu_fetch_ctl_pkg.sv
// Shared definitions for the IFU fetch-request sequencer.
package cpu7_ifu_fetch_ctl_pkg;

    // Width of one fetch block returned by the ICU (two 32-bit instructions).
    localparam int FETCH_W = 64;

    // Number of low address bits cleared to align a fetch to one block.
    localparam int FETCH_ALIGN_BITS = 3;

    // Sequencer states; the encodings are fixed so debug tools can decode them.
    typedef enum logic [1:0] {
        FCTL_IDLE   = 2'd0,
        FCTL_REQ    = 2'd1,
        FCTL_WAIT   = 2'd2,
        FCTL_CANCEL = 2'd3
    } fctl_state_e;

endpackage

// File: rtl/cpu7_sat_cnt.sv
// Parameterised up-counter that sticks at all-ones instead of wrapping.
module cpu7_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = &cnt_q;

    // Next count: step only when enabled and not already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared by the core reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu7_ifu_fetch_ctl.sv
// Fetch-request sequencer between the IFU datapath and the instruction cache.
// Keeps at most one aligned fetch outstanding, holds the request until the
// ICU acknowledges it, forwards the returned block to the instruction queue
// and cancels or drops the in-flight fetch when the pipeline redirects.
module cpu7_ifu_fetch_ctl
    import cpu7_ifu_fetch_ctl_pkg::*;
#(
    parameter int GRLEN = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [GRLEN-1:0]   fetch_pc,
    input  logic               fetch_want,
    input  logic               redirect,
    input  logic [GRLEN-1:0]   redirect_pc,
    input  logic               exu_ifu_stall_req,
    output logic               ifu_icu_req_ic1,
    output logic [GRLEN-1:0]   ifu_icu_addr_ic1,
    input  logic               icu_ifu_ack_ic1,
    output logic               ifu_icu_cancel,
    input  logic [FETCH_W-1:0] icu_ifu_data_ic2,
    input  logic               icu_ifu_data_valid_ic2,
    output logic [FETCH_W-1:0] fctl_iq_data,
    output logic               fctl_iq_valid,
    output logic [GRLEN-1:0]   fctl_iq_pc,
    output logic               fctl_busy,
    output logic [CNT_W-1:0]   fctl_wait_cnt
);

    localparam logic [GRLEN-1:0] ALIGN_MASK = ~GRLEN'((1 << FETCH_ALIGN_BITS) - 1);

    // Clear the in-block offset so every fetch starts on a block boundary.
    function automatic logic [GRLEN-1:0] align_pc(input logic [GRLEN-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

    fctl_state_e      state_q, state_d;
    logic [GRLEN-1:0] addr_q,  addr_d;
    logic [GRLEN-1:0] tgt_q,   tgt_d;

    logic             seq_start;
    logic             iq_valid;
    logic             wait_inc;
    logic [GRLEN-1:0] redirect_al;
    logic [GRLEN-1:0] fetch_al;

    // A new sequential fetch may start only when the queue wants data and
    // the pipeline is not stalled; a redirect bypasses this gate.
    assign seq_start   = fetch_want & ~exu_ifu_stall_req;
    assign redirect_al = align_pc(redirect_pc);
    assign fetch_al    = align_pc(fetch_pc);

    // Next-state, address/target latching and block-forward decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tgt_d    = tgt_q;
        iq_valid = 1'b0;
        wait_inc = 1'b0;

        unique case (state_q)
            FCTL_IDLE: begin
                if (redirect) begin
                    // Queue is flushed by the redirect, so want/stall do not matter.
                    state_d = FCTL_REQ;
                    addr_d  = redirect_al;
                end else if (seq_start) begin
                    state_d = FCTL_REQ;
                    addr_d  = fetch_al;
                end
            end

            FCTL_REQ: begin
                wait_inc = ~icu_ifu_ack_ic1;
                if (icu_ifu_ack_ic1) begin
                    if (redirect) begin
                        // Accepted fetch is already stale: cancel it, remember target.
                        state_d = FCTL_CANCEL;
                        tgt_d   = redirect_al;
                    end else begin
                        state_d = FCTL_WAIT;
                    end
                end else if (redirect) begin
                    // ICU has not sampled the address yet, so just retarget.
                    addr_d = redirect_al;
                end
            end

            FCTL_WAIT: begin
                wait_inc = ~icu_ifu_data_valid_ic2;
                if (icu_ifu_data_valid_ic2) begin
                    if (redirect) begin
                        // Block arrived but is on the wrong path: drop it, no cancel needed.
                        state_d = FCTL_REQ;
                        addr_d  = redirect_al;
                    end else begin
                        iq_valid = 1'b1;
                        if (seq_start) begin
                            state_d = FCTL_REQ;
                            addr_d  = fetch_al;
                        end else begin
                            state_d = FCTL_IDLE;
                        end
                    end
                end else if (redirect) begin
                    state_d = FCTL_CANCEL;
                    tgt_d   = redirect_al;
                end
            end

            FCTL_CANCEL: begin
                // Any data this cycle belongs to the cancelled fetch and is ignored.
                state_d = FCTL_REQ;
                if (redirect) begin
                    tgt_d  = redirect_al;
                    addr_d = redirect_al;
                end else begin
                    addr_d = tgt_q;
                end
            end

            default: begin
                state_d = FCTL_IDLE;
            end
        endcase
    end

    // Sequencer state and latched fetch/redirect addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FCTL_IDLE;
            addr_q  <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
        end
    end

    cpu7_sat_cnt #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (wait_inc),
        .cnt_o (fctl_wait_cnt)
    );

    assign ifu_icu_req_ic1  = (state_q == FCTL_REQ);
    assign ifu_icu_addr_ic1 = addr_q;
    assign ifu_icu_cancel   = (state_q == FCTL_CANCEL);
    assign fctl_busy        = (state_q != FCTL_IDLE);
    assign fctl_iq_valid    = iq_valid;
    assign fctl_iq_data     = iq_valid ? icu_ifu_data_ic2 : '0;
    assign fctl_iq_pc       = addr_q;

endmodule
